// File: rtl/mem_port_arbiter_if.sv
// Pipeline/memory bundle for mem_port_arbiter; "slave" is the arbiter side, "master" the pipeline+memory side.
// Handshake: a requester raises *_req with stable address/data and holds it until it sees the one-cycle *_gnt; the matching *_rvalid pulse later completes the access, so each requester has at most one access in flight.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store; one access in flight, data wins ties.
// Optional macro ARB_STARVE_GUARD_EN lets fetch win after STARVE_MAX consecutive lost arbitrations.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX=%0d must be at least 1", STARVE_MAX);
  end

  state_t            state_q;
  logic [3:0]        lat_q;
  logic              owner_data_q;
  logic              owner_we_q;
  logic              if_gnt_q;
  logic              d_gnt_q;
  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic sample_en;
  logic any_req;
  logic starve_hit;
  logic win_data;
  logic win_fetch;

  // IDLE and DONE are the only cycles in which new requests are looked at.
  assign sample_en = (state_q == S_IDLE) || (state_q == S_DONE);
  assign any_req   = bus.if_req || bus.d_req;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_q;

  assign starve_hit = bus.if_req && (starve_q == STARVE_W'(STARVE_MAX));

  // Counts arbitrations fetch lost while it was asking; any fetch grant restarts it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      starve_q <= '0;
    end else if (sample_en && any_req) begin
      if (win_fetch) begin
        starve_q <= '0;
      end else if (bus.if_req) begin
        starve_q <= starve_q + STARVE_W'(1);
      end
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign win_data  = bus.d_req && !starve_hit;
  assign win_fetch = bus.if_req && !win_data;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      lat_q        <= 4'd0;
      owner_data_q <= 1'b0;
      owner_we_q   <= 1'b0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (any_req) begin
            state_q      <= S_ISSUE;
            owner_data_q <= win_data;
            owner_we_q   <= win_data && bus.d_we;
            if_gnt_q     <= win_fetch;
            d_gnt_q      <= win_data;
            mem_en_q     <= 1'b1;
            mem_we_q     <= win_data && bus.d_we;
            mem_addr_q   <= win_data ? bus.d_addr : bus.if_addr;
            mem_wdata_q  <= (win_data && bus.d_we) ? bus.d_wdata : '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          lat_q   <= LAT_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          lat_q <= lat_q - 4'd1;
          // Count of 1 marks the cycle in which mem_rdata is valid.
          if (lat_q == 4'd1) begin
            state_q <= S_DONE;
            if (owner_data_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= owner_we_q ? '0 : bus.mem_rdata;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps then random traffic, checked against a transaction-timing model
// and a reference memory; build with or without ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam int SMAX = 4;

  logic       clk;
  logic       arst_n;
  logic [1:0] dbg_state;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus state (what the pipeline is asking for)
  logic          s_if_req = 1'b0;
  logic [AW-1:0] s_if_addr = '0;
  logic          s_d_req = 1'b0;
  logic          s_d_we = 1'b0;
  logic [AW-1:0] s_d_addr = '0;
  logic [DW-1:0] s_d_wdata = '0;
  bit            auto_drop = 1'b1;

  // reference model: one transaction at a time, timing from the sampling cycle
  int            m_sample_from = 0;
  int            m_gnt_at = -1;
  int            m_rv_at = -1;
  bit            m_owner_d = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_d_rdata = '0;
  int            m_starve = 0;
  logic [DW-1:0] ref_mem [16];

  // memory device answering the DUT
  logic [DW-1:0] dev_mem [16];
  int            dev_rd_at = -1;
  logic [DW-1:0] dev_rd_val = '0;

  // observation log
  int            obs_if_gnt_n, obs_if_gnt_cyc, obs_d_gnt_n, obs_d_gnt_cyc;
  int            obs_if_rv_n, obs_if_rv_cyc, obs_d_rv_n, obs_d_rv_cyc, obs_men_n;
  logic [DW-1:0] obs_if_rdata, obs_d_rdata, obs_mem_wdata;
  logic          obs_mem_we;
  bit            gnt_seq [$];

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[6:3]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr_obs();
    obs_if_gnt_n = 0; obs_if_gnt_cyc = -1; obs_d_gnt_n = 0; obs_d_gnt_cyc = -1;
    obs_if_rv_n = 0; obs_if_rv_cyc = -1; obs_d_rv_n = 0; obs_d_rv_cyc = -1; obs_men_n = 0;
    obs_if_rdata = '0; obs_d_rdata = '0; obs_mem_wdata = '0; obs_mem_we = 1'b0;
    gnt_seq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, bus.if_gnt, 0);
    chk({tag, "_if_rvalid"}, bus.if_rvalid, 0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 0);
    chk({tag, "_d_gnt"}, bus.d_gnt, 0);
    chk({tag, "_d_rvalid"}, bus.d_rvalid, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  task automatic model_reset();
    m_sample_from = 0; m_gnt_at = -1; m_rv_at = -1;
    m_if_rdata = '0; m_d_rdata = '0; m_starve = 0;
    dev_rd_at = -1; s_if_req = 1'b0; s_d_req = 1'b0;
  endtask

  // driver + scoreboard for one clock cycle; entered just after a rising edge
  task automatic run_cycle();
    bit win_d;
    bit e_if_gnt, e_d_gnt, e_men, e_if_rv, e_d_rv;
    #1;
    bus.if_req    = s_if_req;
    bus.if_addr   = s_if_addr;
    bus.d_req     = s_d_req;
    bus.d_we      = s_d_we;
    bus.d_addr    = s_d_addr;
    bus.d_wdata   = s_d_wdata;
    bus.mem_rdata = (cyc == dev_rd_at) ? dev_rd_val : {$urandom(), $urandom()};
    @(negedge clk);

    e_men    = (cyc == m_gnt_at);
    e_if_gnt = e_men && !m_owner_d;
    e_d_gnt  = e_men && m_owner_d;
    e_if_rv  = (cyc == m_rv_at) && !m_owner_d;
    e_d_rv   = (cyc == m_rv_at) && m_owner_d;
    if (e_if_rv) m_if_rdata = m_rdata;
    if (e_d_rv) m_d_rdata = m_rdata;
    chk("if_gnt", bus.if_gnt, e_if_gnt);
    chk("d_gnt", bus.d_gnt, e_d_gnt);
    chk("mem_en", bus.mem_en, e_men);
    chk("if_rvalid", bus.if_rvalid, e_if_rv);
    chk("d_rvalid", bus.d_rvalid, e_d_rv);
    chk("if_rdata", bus.if_rdata, m_if_rdata);
    chk("d_rdata", bus.d_rdata, m_d_rdata);
    if (e_men) begin
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
    end

    if (bus.mem_en === 1'b1) begin
      obs_men_n++;
      obs_mem_we = bus.mem_we;
      obs_mem_wdata = bus.mem_wdata;
      if (bus.mem_we === 1'b1) begin
        dev_mem[idx(bus.mem_addr)] = bus.mem_wdata;
      end else begin
        dev_rd_at = cyc + LAT;
        dev_rd_val = dev_mem[idx(bus.mem_addr)];
      end
    end
    if (bus.if_gnt === 1'b1) begin obs_if_gnt_n++; obs_if_gnt_cyc = cyc; gnt_seq.push_back(1'b1); end
    if (bus.d_gnt === 1'b1) begin obs_d_gnt_n++; obs_d_gnt_cyc = cyc; gnt_seq.push_back(1'b0); end
    if (bus.if_rvalid === 1'b1) begin obs_if_rv_n++; obs_if_rv_cyc = cyc; obs_if_rdata = bus.if_rdata; end
    if (bus.d_rvalid === 1'b1) begin obs_d_rv_n++; obs_d_rv_cyc = cyc; obs_d_rdata = bus.d_rdata; end

    // arbitration decision at the coming edge, straight from the priority rules
    if (arst_n && cyc >= m_sample_from && (s_if_req || s_d_req)) begin
      win_d = s_d_req;
`ifdef ARB_STARVE_GUARD_EN
      if (s_if_req && m_starve == SMAX) win_d = 1'b0;
`endif
      if (!win_d) m_starve = 0;
      else if (s_if_req) m_starve++;
      m_owner_d = win_d;
      m_gnt_at = cyc + 1;
      m_rv_at = cyc + 2 + LAT;
      m_sample_from = cyc + 2 + LAT;
      if (win_d) begin
        m_we = s_d_we;
        m_addr = s_d_addr;
        m_wdata = s_d_we ? s_d_wdata : '0;
        if (s_d_we) ref_mem[idx(s_d_addr)] = s_d_wdata;
        m_rdata = s_d_we ? '0 : ref_mem[idx(s_d_addr)];
      end else begin
        m_we = 1'b0;
        m_addr = s_if_addr;
        m_wdata = '0;
        m_rdata = ref_mem[idx(s_if_addr)];
      end
    end

    if (auto_drop) begin
      if (bus.if_gnt === 1'b1) s_if_req = 1'b0;
      if (bus.d_gnt === 1'b1) s_d_req = 1'b0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    int b;
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = {$urandom(), $urandom()};
      dev_mem[i] = ref_mem[i];
    end
    arst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    clr_obs();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    arst_n = 1'b1;
    @(posedge clk);
    cyc = 0;

    // fetch alone
    ref_mem[idx(64'h100)] = 64'hDEAD;
    dev_mem[idx(64'h100)] = 64'hDEAD;
    clr_obs();
    b = cyc;
    s_if_req = 1'b1; s_if_addr = 64'h100;
    run_n(8);
    chk("fetch_gnt_cycle", obs_if_gnt_cyc, b + 1);
    chk("fetch_rvalid_cycle", obs_if_rv_cyc, b + 2 + LAT);
    chk("fetch_rdata", obs_if_rdata, 64'hDEAD);
    chk("fetch_mem_en_count", obs_men_n, 1);

    // simultaneous load and fetch
    ref_mem[idx(64'h200)] = 64'hCAFE; dev_mem[idx(64'h200)] = 64'hCAFE;
    ref_mem[idx(64'h108)] = 64'h1111; dev_mem[idx(64'h108)] = 64'h1111;
    clr_obs();
    b = cyc;
    s_if_req = 1'b1; s_if_addr = 64'h108;
    s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 64'h200;
    run_n(12);
    chk("both_d_gnt_cycle", obs_d_gnt_cyc, b + 1);
    chk("both_d_rvalid_cycle", obs_d_rv_cyc, b + 4);
    chk("both_if_gnt_cycle", obs_if_gnt_cyc, b + 5);
    chk("both_if_rvalid_cycle", obs_if_rv_cyc, b + 8);
    chk("both_d_rdata", obs_d_rdata, 64'hCAFE);
    chk("both_if_rdata", obs_if_rdata, 64'h1111);

    // store, then read it back
    clr_obs();
    s_d_req = 1'b1; s_d_we = 1'b1; s_d_addr = 64'h40; s_d_wdata = 64'h1234;
    run_n(8);
    chk("store_mem_en_count", obs_men_n, 1);
    chk("store_mem_we", obs_mem_we, 1);
    chk("store_mem_wdata", obs_mem_wdata, 64'h1234);
    chk("store_d_rvalid_count", obs_d_rv_n, 1);
    chk("store_d_rdata", obs_d_rdata, 0);
    chk("store_if_rvalid_count", obs_if_rv_n, 0);
    clr_obs();
    s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 64'h40;
    run_n(8);
    chk("store_readback", obs_d_rdata, 64'h1234);

    // fetch request withdrawn before the sampling edge
    clr_obs();
    #1 bus.if_req = 1'b1; bus.if_addr = 64'h300;
    #2 bus.if_req = 1'b0;
    @(posedge clk);
    cyc++;
    run_n(6);
    chk("withdraw_if_gnt_count", obs_if_gnt_n, 0);
    chk("withdraw_mem_en_count", obs_men_n, 0);

    // both requests held high continuously
    clr_obs();
    auto_drop = 1'b0;
    s_if_req = 1'b1; s_if_addr = 64'h500;
    s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 64'h600;
    run_n(41);
    chk("held_grant_count", gnt_seq.size(), 10);
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      chk("held_grant_owner", gnt_seq[k], (k % 5) == 4);
`else
      chk("held_grant_owner", gnt_seq[k], 0);
`endif
    end
    s_if_req = 1'b0; s_d_req = 1'b0;
    auto_drop = 1'b1;
    run_n(8);

    // reset during WAIT
    b = cyc;
    s_if_req = 1'b1; s_if_addr = 64'h180;
    run_n(2);
    #1 arst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    model_reset();
    run_n(2);
    #1 arst_n = 1'b1;
    clr_obs();
    run_n(10);
    chk("rst_quiet_if_rvalid", obs_if_rv_n, 0);
    chk("rst_quiet_d_rvalid", obs_d_rv_n, 0);
    clr_obs();
    b = cyc;
    exp_rd = ref_mem[idx(64'h188)];
    s_if_req = 1'b1; s_if_addr = 64'h188;
    run_n(8);
    chk("rst_after_gnt_cycle", obs_if_gnt_cyc, b + 1);
    chk("rst_after_rvalid_cycle", obs_if_rv_cyc, b + 2 + LAT);
    chk("rst_after_rdata", obs_if_rdata, exp_rd);

    // random traffic
    clr_obs();
    for (int i = 0; i < 2000; i++) begin
      if (!s_if_req && $urandom_range(0, 3) == 0) begin
        s_if_req = 1'b1;
        s_if_addr = {$urandom(), $urandom()} & ~64'h7;
      end else if (s_if_req && $urandom_range(0, 31) == 0) begin
        s_if_req = 1'b0;
      end
      if (!s_d_req && $urandom_range(0, 2) == 0) begin
        s_d_req = 1'b1;
        s_d_we = 1'($urandom_range(0, 1));
        s_d_addr = {$urandom(), $urandom()} & ~64'h7;
        s_d_wdata = {$urandom(), $urandom()};
      end else if (s_d_req && $urandom_range(0, 31) == 0) begin
        s_d_req = 1'b0;
      end
      run_cycle();
    end
    s_if_req = 1'b0; s_d_req = 1'b0;
    run_n(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
